// File: rtl/fifo_ptr_counter_if.sv
// Handshake/bus bundle for one FIFO pointer counter.
// The master drives the control strobes, and the slave (the counter) returns the pointer state.
interface fifo_ptr_counter_if #(
  parameter int ADDR_W = 3
) ();
  logic              clr;
  logic              flag;
  logic              valid;
  logic              load;
  logic [ADDR_W:0]   load_val;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   gray;
  logic              wrap_pulse;
  logic              at_last;
  logic              sat;

  modport master (
    output clr, flag, valid, load, load_val,
    input  count, addr, gray, wrap_pulse, at_last, sat
  );

  modport slave (
    input  clr, flag, valid, load, load_val,
    output count, addr, gray, wrap_pulse, at_last, sat
  );
endinterface

// File: rtl/fifo_ptr_counter.sv
// FIFO pointer counter: address modulo DEPTH plus wrap bit, with wrap or saturate mode, clear, load and a wrap pulse.
// Define FIFO_PTR_GRAY_EN to get a registered Gray copy of count; otherwise gray is tied to 0.
module fifo_ptr_counter #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int MODE   = 0
) (
  input logic               clk,
  input logic               n_rst,
  fifo_ptr_counter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_d;
  logic            wrap_q;
  logic            wrap_d;
  logic            adv;
  logic            at_last;

  assign adv     = bus.valid & ~bus.flag;
  assign at_last = (count_q[ADDR_W-1:0] == LAST);

  // Priority is clr > load > adv > hold. The wrap bit only changes by explicit toggle or by load.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d[ADDR_W]     = bus.load_val[ADDR_W];
      count_d[ADDR_W-1:0] = (bus.load_val[ADDR_W-1:0] > LAST) ? LAST : bus.load_val[ADDR_W-1:0];
    end else if (adv) begin
      if (!at_last) begin
        count_d[ADDR_W-1:0] = count_q[ADDR_W-1:0] + ADDR_W'(1);
      end else if (MODE == 0) begin
        count_d = {~count_q[ADDR_W], {ADDR_W{1'b0}}};
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef FIFO_PTR_GRAY_EN
  logic [ADDR_W:0] gray_q;

  // Gray is encoded from the next-state value, so it stays cycle-aligned with count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign bus.gray = gray_q;
`else
  assign bus.gray = '0;
`endif

  assign bus.count      = count_q;
  assign bus.addr       = count_q[ADDR_W-1:0];
  assign bus.wrap_pulse = wrap_q;
  assign bus.at_last    = at_last;
  assign bus.sat        = (MODE == 1) ? (adv & at_last) : 1'b0;

endmodule

// File: tb/tb_fifo_ptr_counter.sv
// Directed bench for fifo_ptr_counter: wrap mode (DEPTH 6), saturate mode (DEPTH 6) and a full DEPTH 8 sweep.
module tb_fifo_ptr_counter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  fifo_ptr_counter_if #(.ADDR_W(3)) if0 ();
  fifo_ptr_counter_if #(.ADDR_W(3)) if1 ();
  fifo_ptr_counter_if #(.ADDR_W(3)) if2 ();

  fifo_ptr_counter #(.ADDR_W(3), .DEPTH(6), .MODE(0)) u_wrap (.clk(clk), .n_rst(n_rst), .bus(if0));
  fifo_ptr_counter #(.ADDR_W(3), .DEPTH(6), .MODE(1)) u_sat  (.clk(clk), .n_rst(n_rst), .bus(if1));
  fifo_ptr_counter #(.ADDR_W(3), .DEPTH(8), .MODE(0)) u_full (.clk(clk), .n_rst(n_rst), .bus(if2));

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gray_of(input logic [3:0] c);
`ifdef FIFO_PTR_GRAY_EN
    return {4'h0, c ^ (c >> 1)};
`else
    return 8'h00 & {4'h0, c};
`endif
  endfunction

  initial begin
    int exp_wrap[8];
    int exp_sat[8];
    logic [3:0] prev_gray;
    logic [3:0] c2;

    exp_wrap = '{1, 2, 3, 4, 5, 8, 9, 9};
    exp_sat  = '{1, 2, 3, 4, 5, 5, 5, 5};
    {if0.clr, if0.flag, if0.valid, if0.load, if0.load_val} = '0;
    {if1.clr, if1.flag, if1.valid, if1.load, if1.load_val} = '0;
    {if2.clr, if2.flag, if2.valid, if2.load, if2.load_val} = '0;

    #2;
    check_output("rst_count", {4'h0, if0.count}, 8'h00);
    check_output("rst_gray", {4'h0, if0.gray}, 8'h00);
    check_output("rst_wrap_pulse", {7'h0, if0.wrap_pulse}, 8'h00);
    check_output("rst_at_last", {7'h0, if0.at_last}, 8'h00);
    check_output("rst_sat", {7'h0, if1.sat}, 8'h00);

    @(negedge clk);
    n_rst = 1'b1;
    prev_gray = 4'h0;

    // Wrap and saturate run for 7/8 requests while the DEPTH 8 instance sweeps all 16 states.
    for (int i = 0; i < 16; i++) begin
      if0.valid = (i < 7);
      if1.valid = (i < 8);
      if2.valid = 1'b1;
      tick();
      if (i < 8) begin
        check_output($sformatf("wrap_count_%0d", i), {4'h0, if0.count}, 8'(exp_wrap[i]));
        check_output($sformatf("wrap_pulse_%0d", i), {7'h0, if0.wrap_pulse}, {7'h0, i == 5});
        check_output($sformatf("wrap_at_last_%0d", i), {7'h0, if0.at_last}, {7'h0, exp_wrap[i] == 5});
        check_output($sformatf("sat_count_%0d", i), {4'h0, if1.count}, 8'(exp_sat[i]));
        check_output($sformatf("sat_flag_%0d", i), {7'h0, if1.sat}, {7'h0, i >= 4});
        check_output($sformatf("sat_wrap_pulse_%0d", i), {7'h0, if1.wrap_pulse}, 8'h00);
      end
      c2 = 4'(i + 1);
      check_output($sformatf("sweep_count_%0d", i), {4'h0, if2.count}, {4'h0, c2});
      check_output($sformatf("sweep_gray_%0d", i), {4'h0, if2.gray}, gray_of(c2));
`ifdef FIFO_PTR_GRAY_EN
      check_output($sformatf("sweep_gray_step_%0d", i), 8'($countones(if2.gray ^ prev_gray)), 8'd1);
`endif
      prev_gray = if2.gray;
    end
    if2.valid = 1'b0;
    if1.valid = 1'b0;

    // Flag holds off advancing at count 3, then release.
    if0.load = 1'b1; if0.load_val = 4'd3;
    tick();
    if0.load = 1'b0;
    check_output("flag_load3", {4'h0, if0.count}, 8'h03);
    if0.valid = 1'b1; if0.flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output($sformatf("flag_hold_%0d", i), {4'h0, if0.count}, 8'h03);
    end
    if0.flag = 1'b0;
    tick();
    check_output("flag_release", {4'h0, if0.count}, 8'h04);
    if0.valid = 1'b0;

    // Load clamps an out-of-range address and never pulses wrap.
    if0.load = 1'b1; if0.load_val = 4'b1111;
    tick();
    check_output("load_clamp", {4'h0, if0.count}, 8'h0d);
    check_output("load_clamp_at_last", {7'h0, if0.at_last}, 8'h01);
    check_output("load_no_pulse", {7'h0, if0.wrap_pulse}, 8'h00);
    if0.clr = 1'b1;
    tick();
    check_output("clr_over_load", {4'h0, if0.count}, 8'h00);
    if0.clr = 1'b0; if0.load_val = 4'd2;
    tick();
    check_output("load2", {4'h0, if0.count}, 8'h02);
    if0.valid = 1'b1; if0.load_val = 4'b1011;
    tick();
    check_output("load_over_adv", {4'h0, if0.count}, 8'h0b);
    if0.load = 1'b0;

    // Build up to count 9 via a wrap, then reset between edges.
    if0.valid = 1'b0; if0.load = 1'b1; if0.load_val = 4'd5;
    tick();
    if0.load = 1'b0; if0.valid = 1'b1;
    tick();
    check_output("pre_rst_count8", {4'h0, if0.count}, 8'h08);
    check_output("pre_rst_pulse", {7'h0, if0.wrap_pulse}, 8'h01);
    tick();
    check_output("pre_rst_count9", {4'h0, if0.count}, 8'h09);
    #3;
    n_rst = 1'b0;
    #1;
    check_output("midrst_count", {4'h0, if0.count}, 8'h00);
    check_output("midrst_gray", {4'h0, if0.gray}, 8'h00);
    check_output("midrst_pulse", {7'h0, if0.wrap_pulse}, 8'h00);
    check_output("midrst_full_count", {4'h0, if2.count}, 8'h00);
    if0.valid = 1'b0;

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_counter.md
# fifo_ptr_counter

Parametrised FIFO pointer counter: the next-generation replacement for the plain 4-bit up counter used as FIFO read/write pointers. Tracks an address modulo an arbitrary `DEPTH`, with an extra wrap bit for full/empty comparison. It also provides a saturating mode, synchronous clear and load, a registered wrap pulse, and an optional registered Gray-coded copy for clock-domain crossing. One instance drives each FIFO pointer (read or write).

## Interface
- `ADDR_W`, 3: address field width; `count` is `ADDR_W+1` bits.
- `DEPTH`, 8: number of FIFO entries; legal range 2 ≤ DEPTH ≤ 2^ADDR_W.
- `MODE`, 0: 0 = wrap (modulo DEPTH, toggles wrap bit); 1 = saturate at DEPTH-1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear, active high.
- `flag`  in  1  active-high block (full flag for write pointer, empty flag for read pointer); when high, advance is inhibited.
- `valid`  in  1  advance request.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  ADDR_W+1  value to load: MSB is the wrap bit, low bits are the address.
- `count`  out  ADDR_W+1  {wrap bit, address}.
- `addr`  out  ADDR_W  address field of `count`.
- `gray`  out  ADDR_W+1  Gray code of `count` (see Configuration).
- `wrap_pulse`  out  1  one-cycle pulse after an advance that wrapped the address.
- `at_last`  out  1  high while `addr == DEPTH-1`.
- `sat`  out  1  MODE 1 only: high while an advance request is being held off at DEPTH-1; always 0 in MODE 0.

## Operation
- Advance condition: `adv = valid & ~flag`.
- Next-state priority, evaluated each rising edge: `clr` > `load` > `adv` > hold.
- `clr`: count ← 0; wrap_pulse ← 0.
- `load`:
  - wrap bit ← `load_val[ADDR_W]`.
  - addr ← `load_val[ADDR_W-1:0]`, clamped to DEPTH-1 when ≥ DEPTH.
  - Does not assert wrap_pulse.
- `adv` with addr < DEPTH-1: addr ← addr+1; wrap bit unchanged.
- `adv` with addr == DEPTH-1:
  - MODE 0: addr ← 0; wrap bit toggles; wrap_pulse ← 1 for the next cycle.
  - MODE 1: hold; `sat` = 1 for that cycle (combinational from adv and at_last).
- Hold: all state unchanged. wrap_pulse is 0 in any cycle not immediately following a wrapping advance.
- Arithmetic: the address never reaches a value ≥ DEPTH. No carry leaks from the address field into the wrap bit; the wrap bit changes only by explicit toggle or by load.
- `at_last` is decoded from the registered addr.

## Timing
- Reset (`n_rst` low, asynchronous): count = 0, addr = 0, gray = 0, wrap_pulse = 0. Consequently at_last = 0 (DEPTH ≥ 2) and sat = 0.
- Latency: an input sampled at edge N is visible on count/addr/gray at edge N plus clock-to-q. wrap_pulse is high during the cycle after edge N.
- `gray` is registered from the next-state value, so it is cycle-aligned with `count`. There is no combinational path from inputs to `gray`.
- Reset asserted mid-operation clears everything immediately. Deassertion is assumed synchronised externally. The first advance can occur at the first edge after release.
- `clr` and `load` asserted together: clr wins.
- Load concurrent with `adv`: the load wins and the advance is dropped.
- Gray single-bit-change property across the wrap holds only when DEPTH == 2^ADDR_W. For other DEPTH values, the consumer must not use `gray` for asynchronous crossing.

## Configuration
- Macro: `FIFO_PTR_GRAY_EN`.
- Defined: the Gray register is implemented; `gray = count ^ (count >> 1)`, registered.
- Undefined: the Gray register and its logic are omitted; `gray` is tied to 0. All other behaviour is identical.

## Test plan
- Wrap, MODE 0, ADDR_W=3, DEPTH=6:
  - Stimulus: reset, then valid=1, flag=0 for 7 cycles.
  - Response: count steps 0,1,2,3,4,5,8,9 (8 = wrap bit set, addr 0).
  - wrap_pulse is high exactly in the cycle where count=8; at_last is high while addr=5.
- Flag block: hold flag=1 with valid=1 at count=3 for 4 cycles → count stays 3. Drop flag → count becomes 4 on the next edge.
- Saturate, MODE 1, DEPTH=6: 8 advances from reset → count stops at 5; sat=1 on each held request; wrap_pulse never asserts.
- Load and priority:
  - load=1, load_val=4'b1111 → count=4'b1101 (addr clamped to 5).
  - Same cycle with clr=1 → count=0.
  - load together with adv from count=2 → count = load_val.
- Reset mid-run: drop n_rst between edges at count=9 → count, gray and wrap_pulse go to 0 before the next edge.
- Gray, with `FIFO_PTR_GRAY_EN` defined, ADDR_W=3, DEPTH=8:
  - Full 16-step sweep: gray matches count^(count>>1) every cycle, and exactly one bit changes per advance, including 7→8 and 15→0.
  - Macro undefined: gray stays 0.
